// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the two-digit multiplexed seven-segment scanner.
// Segment patterns are active-low with seg[7] = dp held dark.
package seg_scan_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHOW_ONES = 3'd1,
        GAP_A     = 3'd2,
        SHOW_TENS = 3'd3,
        GAP_B     = 3'd4
    } state_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // One-cold digit enables: an[0] = ones, an[1] = tens.
    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;
    localparam logic [1:0] AN_OFF  = 2'b11;

endpackage

// File: rtl/seg_scan_dec7.sv
// Combinational 7-bit digit value to active-low segment pattern; values above 9 show 'E'.
module seg_dec7
    import seg_scan_pkg::*;
(
    input  logic [6:0] val,
    output logic [7:0] pat
);

    always_comb begin
        pat = SEG_E;
        case (val)
            7'd0: pat = SEG_0;
            7'd1: pat = SEG_1;
            7'd2: pat = SEG_2;
            7'd3: pat = SEG_3;
            7'd4: pat = SEG_4;
            7'd5: pat = SEG_5;
            7'd6: pat = SEG_6;
            7'd7: pat = SEG_7;
            7'd8: pat = SEG_8;
            7'd9: pat = SEG_9;
            default: pat = SEG_E;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// Two-digit scanner: ones, dark gap, tens, dark gap, with both digits latched once per frame.
// Outputs are registered and already reflect the state being entered on that edge.
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned GAP_CYC  = 2,
    parameter bit          LZ_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       rest,
    input  logic       en,
    input  logic [6:0] in_ones,
    input  logic [6:0] in_tens,
    output logic [7:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam int unsigned MAXL = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
    localparam int unsigned CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

    state_t        state, nstate;
    logic [CW-1:0] cnt, ncnt;
    logic [6:0]    ones_sh, tens_sh, ones_n, tens_n, dig;
    logic [7:0]    pat, seg_n;
    logic [1:0]    an_n;
    logic          latch, show_last, gap_last, err_n;

    assign show_last = (cnt == CW'(SCAN_DIV - 1));
    assign gap_last  = (cnt == CW'(GAP_CYC - 1));

    always_comb begin
        nstate = state;
        latch  = 1'b0;
        if (!en) begin
            nstate = IDLE;
        end else begin
            case (state)
                IDLE:      begin nstate = SHOW_ONES; latch = 1'b1; end
                SHOW_ONES: if (show_last) nstate = GAP_A;
                GAP_A:     if (gap_last)  nstate = SHOW_TENS;
                SHOW_TENS: if (show_last) nstate = GAP_B;
                GAP_B:     if (gap_last)  begin nstate = SHOW_ONES; latch = 1'b1; end
                default:   nstate = IDLE;
            endcase
        end
        ncnt = (nstate != state || nstate == IDLE) ? '0 : cnt + CW'(1);

        // Decode from the post-edge shadow so the latch edge already shows the new digit.
        ones_n = latch ? in_ones : ones_sh;
        tens_n = latch ? in_tens : tens_sh;
        dig    = (nstate == SHOW_TENS) ? tens_n : ones_n;
        err_n  = err | (latch && (in_ones > 7'd9 || in_tens > 7'd9));

        seg_n = SEG_BLANK;
        an_n  = AN_OFF;
        case (nstate)
            SHOW_ONES: begin
                seg_n = pat;
                an_n  = AN_ONES;
            end
            SHOW_TENS: begin
                seg_n = (LZ_BLANK && tens_n == '0) ? SEG_BLANK : pat;
                an_n  = AN_TENS;
            end
            default: ;
        endcase
    end

    seg_dec7 u_dec (
        .val (dig),
        .pat (pat)
    );

    always_ff @(posedge clk) begin
        if (rest) begin
            state   <= IDLE;
            cnt     <= '0;
            ones_sh <= '0;
            tens_sh <= '0;
            seg     <= SEG_BLANK;
            an      <= AN_OFF;
            err     <= 1'b0;
        end else begin
            state   <= nstate;
            cnt     <= ncnt;
            ones_sh <= ones_n;
            tens_sh <= tens_n;
            seg     <= seg_n;
            an      <= an_n;
            err     <= err_n;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: directed scenarios plus random traffic against a frame-position model.
// Two instances share inputs and differ only in leading-zero blanking.
module tb_seg_scan;

    localparam int SD    = 4;
    localparam int GC    = 2;
    localparam int FRAME = 2 * SD + 2 * GC;

    logic       clk = 1'b0;
    logic       rest, en;
    logic [6:0] in_ones, in_tens;
    logic [7:0] seg, seg0;
    logic [1:0] an, an0;
    logic       err, err0;

    int checks   = 0;
    int failures = 0;

    // Model: position within the frame (-1 = dark/idle) and the digits latched at its start.
    int         pos = -1;
    logic [6:0] m_ones = '0, m_tens = '0;
    logic       m_err = 1'b0;

    always #5 clk = ~clk;

    seg_scan #(.SCAN_DIV(SD), .GAP_CYC(GC), .LZ_BLANK(1'b1)) dut (
        .clk(clk), .rest(rest), .en(en), .in_ones(in_ones), .in_tens(in_tens),
        .seg(seg), .an(an), .err(err)
    );

    seg_scan #(.SCAN_DIV(SD), .GAP_CYC(GC), .LZ_BLANK(1'b0)) dut0 (
        .clk(clk), .rest(rest), .en(en), .in_ones(in_ones), .in_tens(in_tens),
        .seg(seg0), .an(an0), .err(err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t pos=%0d", tag, got, exp, $time, pos);
        end
    endtask

    function automatic logic [7:0] glyph(input logic [6:0] v);
        case (v)
            7'd0: return 8'hC0;  7'd1: return 8'hF9;  7'd2: return 8'hA4;
            7'd3: return 8'hB0;  7'd4: return 8'h99;  7'd5: return 8'h92;
            7'd6: return 8'h82;  7'd7: return 8'hF8;  7'd8: return 8'h80;
            7'd9: return 8'h90;
            default: return 8'h86;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input bit lz);
        if (pos < 0)            return 8'hFF;
        if (pos < SD)           return glyph(m_ones);
        if (pos < SD + GC)      return 8'hFF;
        if (pos < 2 * SD + GC)  return (lz && m_tens == 7'd0) ? 8'hFF : glyph(m_tens);
        return 8'hFF;
    endfunction

    function automatic logic [1:0] exp_an();
        if (pos < 0)            return 2'b11;
        if (pos < SD)           return 2'b10;
        if (pos < SD + GC)      return 2'b11;
        if (pos < 2 * SD + GC)  return 2'b01;
        return 2'b11;
    endfunction

    task automatic model_step();
        if (rest) begin
            pos = -1; m_ones = '0; m_tens = '0; m_err = 1'b0;
        end else if (!en) begin
            pos = -1;
        end else begin
            pos = (pos < 0) ? 0 : (pos + 1) % FRAME;
            if (pos == 0) begin
                m_ones = in_ones;
                m_tens = in_tens;
                if (in_ones > 7'd9 || in_tens > 7'd9) m_err = 1'b1;
            end
        end
    endtask

    task automatic tick(input logic r, input logic e, input logic [6:0] o, input logic [6:0] t);
        rest = r; en = e; in_ones = o; in_tens = t;
        @(posedge clk);
        model_step();
        #1;
        check("seg_lz1", seg,  exp_seg(1'b1));
        check("an_lz1",  an,   exp_an());
        check("err_lz1", err,  m_err);
        check("seg_lz0", seg0, exp_seg(1'b0));
        check("an_lz0",  an0,  exp_an());
        check("err_lz0", err0, m_err);
    endtask

    initial begin
        logic [6:0] o, t;

        // Reset state
        tick(1, 1, 7'd7, 7'd3);
        tick(1, 1, 7'd7, 7'd3);
        check("rst_seg", seg, 32'hFF);
        check("rst_an",  an,  32'h3);

        // Basic frame 7/3, two full frames
        tick(0, 1, 7'd7, 7'd3);
        check("first_ones_seg", seg, 32'hF8);
        check("first_ones_an",  an,  32'h2);
        for (int i = 0; i < 2 * FRAME - 1; i++) tick(0, 1, 7'd7, 7'd3);

        // Leading-zero blanking on tens = 0
        for (int i = 0; i < 2 * FRAME; i++) tick(0, 1, 7'd5, 7'd0);

        // Ones changes 1 -> 2 mid-frame; only the next frame may show it
        while (pos != 0) tick(0, 1, 7'd1, 7'd4);
        for (int i = 0; i < SD + GC + 1; i++) tick(0, 1, 7'd1, 7'd4);
        for (int i = 0; i < FRAME + SD; i++) tick(0, 1, 7'd2, 7'd4);

        // Enable drop mid SHOW_ONES, then a full fresh frame
        while (pos != 1) tick(0, 1, 7'd6, 7'd8);
        tick(0, 0, 7'd6, 7'd8);
        check("en_drop_an", an, 32'h3);
        for (int i = 0; i < FRAME; i++) tick(0, 1, 7'd9, 7'd8);

        // Out-of-range digit sets sticky err until reset
        while (pos != FRAME - 1) tick(0, 1, 7'd9, 7'd8);
        tick(0, 1, 7'd12, 7'd1);
        check("err_seg_E", seg, 32'h86);
        check("err_set",   err, 32'h1);
        for (int i = 0; i < 2 * FRAME; i++) tick(0, 1, 7'd4, 7'd1);
        check("err_sticky", err, 32'h1);
        tick(1, 1, 7'd4, 7'd1);
        check("err_clear", err, 32'h0);

        // Reset during SHOW_TENS with en held high
        while (pos != SD + GC + 1) tick(0, 1, 7'd3, 7'd5);
        tick(1, 1, 7'd0, 7'd0);
        tick(0, 1, 7'd0, 7'd0);
        check("post_rst_seg", seg, 32'hC0);
        for (int i = 0; i < FRAME; i++) tick(0, 1, 7'd0, 7'd0);

        // Random traffic
        o = 7'd0; t = 7'd0;
        for (int i = 0; i < 3000; i++) begin
            logic r, e;
            if ($urandom_range(0, 4) == 0) o = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 9));
            if ($urandom_range(0, 4) == 0) t = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 9));
            r = ($urandom_range(0, 149) == 0);
            e = ($urandom_range(0, 39) != 0);
            tick(r, e, o, t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles each digit is lit; legal range >=1.
REQ-002 Parameter GAP_CYC, default 2, all-dark cycles between digits for anti-ghosting; legal range >=1.
REQ-003 Parameter LZ_BLANK, default 1, 1 = tens digit dark when its value is 0.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rest  in  1  reset, synchronous, active-high.
REQ-006 en  in  1  1 = scan display, 0 = display dark.
REQ-007 in_ones  in  7  units digit from the 0-99 counter, binary, legal 0-9.
REQ-008 in_tens  in  7  tens digit from the 0-99 counter, binary, legal 0-9.
REQ-009 seg  out  8  registered, active-low segments; seg[0..6] = a..g, seg[7] = dp.
REQ-010 an  out  2  registered, active-low digit enable; an[0] = ones, an[1] = tens.
REQ-011 err  out  1  registered sticky flag; set when a latched digit exceeds 9.

Function
REQ-012 FSM states: IDLE, SHOW_ONES, GAP_A, SHOW_TENS, GAP_B.
REQ-013 IDLE -> SHOW_ONES when en=1; any state -> IDLE on the first edge with en=0.
REQ-014 SHOW_ONES and SHOW_TENS each last exactly SCAN_DIV cycles; GAP_A and GAP_B each last exactly GAP_CYC cycles.
REQ-015 Sequence SHOW_ONES -> GAP_A -> SHOW_TENS -> GAP_B -> SHOW_ONES; frame = 2*SCAN_DIV + 2*GAP_CYC cycles.
REQ-016 A single dwell counter counts 0..limit-1 and clears on every state change; width = clog2 of max(SCAN_DIV, GAP_CYC).
REQ-017 in_ones and in_tens are both latched into shadow registers on the same edge that enters SHOW_ONES; input changes mid-frame are invisible until the next frame, so no tearing.
REQ-018 Outputs are registered and take the new state's values on the same edge the state changes.
REQ-019 In IDLE, GAP_A and GAP_B: seg=8'hFF and an=2'b11.
REQ-020 In SHOW_ONES: an=2'b10; in SHOW_TENS: an=2'b01.
REQ-021 Decode (seg hex): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90; shadow value >9 shows E=86.
REQ-022 With LZ_BLANK=1 and shadow tens = 0: SHOW_TENS drives seg=8'hFF, an=2'b01, and timing is unchanged.
REQ-023 err sets on the latch edge if either latched value is >9 and holds until rest.
REQ-024 dp (seg[7]) is 1 in all states.

Reset
REQ-025 rest=1 at an edge forces: state IDLE, dwell counter 0, shadows 0, seg=8'hFF, an=2'b11, err=0.
REQ-026 rest overrides en, including mid-frame; with en=1 and rest=0, the first edge after release enters SHOW_ONES.

Structure
REQ-027 Shared package holds the state enum, the segment constants (digits 0-9, E, BLANK) and the AN_* one-cold constants.
REQ-028 One sub-module, seg_dec7: combinational 7-bit value -> 8-bit active-low pattern including E for >9; instanced once on the muxed shadow digit.

Verification
REQ-029 SCAN_DIV=4, GAP_CYC=2, en=1, ones=7, tens=3 -> repeating frame of 12 cycles: 4x(an=10, seg=F8), 2x(an=11, seg=FF), 4x(an=01, seg=B0), 2x(an=11, seg=FF).
REQ-030 ones=5, tens=0, LZ_BLANK=1 -> SHOW_TENS drives an=01, seg=FF; with LZ_BLANK=0 -> seg=C0.
REQ-031 Change ones 1->2 during SHOW_TENS -> GAP_B still dark; the next SHOW_ONES shows A4; no F9/A4 mix within one frame.
REQ-032 Drop en for 1 cycle mid SHOW_ONES -> next edge IDLE (FF/11); on re-enable, SHOW_ONES runs a full 4 cycles with a fresh latch.
REQ-033 ones=12 -> SHOW_ONES seg=86, err=1; err stays 1 after ones returns to 4 until rest pulse, then 0.
REQ-034 rest=1 with en=1 during SHOW_TENS -> next edge seg=FF, an=11, err=0; first edge after release enters SHOW_ONES showing C0 (shadow 0).
